// File: rtl/cpu_pkg.sv
// Shared AHB-Lite encodings, the TCM slave state type and transfer-decode helpers.
// Byte lanes are big-endian: address offset 0 maps to bits [31:24] (byte enable bit 3).
package cpu_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;

  localparam logic AHB_OKAY  = 1'b0;
  localparam logic AHB_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_ERR1,
    S_ERR2
  } AhbSlvState;

  // Oversized transfers and misaligned halfwords/words are rejected.
  function automatic logic ahb_legal(input logic [2:0] size, input logic [1:0] a);
    logic ok;
    ok = 1'b1;
    if (size > HSIZE_W) ok = 1'b0;
    else if (size == HSIZE_H && a[0]) ok = 1'b0;
    else if (size == HSIZE_W && a != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] ahb_be(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      HSIZE_B: be = 4'b1000 >> a;
      HSIZE_H: be = a[1] ? 4'b0011 : 4'b1100;
      HSIZE_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_wbuf.sv
// One-entry posted write buffer: load wins over drain, reads see buffered bytes merged over SRAM data.
// Load/drain take effect at the clock edge; the merge path is purely combinational.
module ahb_wbuf
  import cpu_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_be,
  input  logic [31:0]   ld_data,
  input  logic [AW-3:0] rd_word,
  input  logic [31:0]   rd_q,
  output logic [31:0]   merged,
  output logic          buf_vld,
  output logic [AW-1:0] buf_addr,
  output logic [3:0]    buf_be,
  output logic [31:0]   buf_data
);

  logic hit;

  assign hit = buf_vld && (buf_addr[AW-1:2] == rd_word);

  always_comb begin
    merged = rd_q;
    for (int i = 0; i < 4; i++) begin
      if (hit && buf_be[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_be   <= '0;
      buf_data <= '0;
    end else if (load) begin
      buf_vld  <= 1'b1;
      buf_addr <= ld_addr;
      buf_be   <= ld_be;
      buf_data <= ld_data;
    end else if (drain) begin
      buf_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_tcm_slave.sv
// AHB-Lite slave in front of a synchronous single-port SRAM; writes are posted (zero wait), reads take 1+RD_WS cycles.
// HREADYOUT drops for RD_WS read waits, one cycle when a read meets a full write buffer, and in the first ERROR cycle.
module ahb_tcm_slave
  import cpu_pkg::*;
#(
  parameter int AW    = 18,
  parameter int RD_WS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          mem_sel,
  output logic          mem_wr,
  output logic [AW-1:0] mem_a,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_d,
  input  logic [31:0]   mem_q
);

  AhbSlvState    state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic          dp_rd, dp_wr;
  logic [AW-1:0] dp_addr;
  logic [3:0]    dp_be;
  logic [31:0]   hrdata_q;

  logic          legal_now, accept, rd_issue, ill_issue, wr_accept;
  logic          stall, load, drain, rd_now, rd_done;
  logic [3:0]    be_now;
  logic [31:0]   merged;
  logic          buf_vld;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_be;
  logic [31:0]   buf_data;
  logic          unused_ok;

  assign unused_ok = ^{HADDR[31:AW], HTRANS[0]};

  assign legal_now = ahb_legal(HSIZE, HADDR[1:0]);
  assign be_now    = ahb_be(HSIZE, HADDR[1:0]);
  assign accept    = !rst && HSEL && HTRANS[1] && HREADY;
  assign rd_issue  = accept && !HWRITE && legal_now;
  assign wr_accept = accept && HWRITE && legal_now;
  assign ill_issue = accept && !legal_now;

  // A legal read arriving while a write data phase would reload a full buffer
  // leaves no SRAM slot to drain the old entry, so hold the bus for one cycle.
  // Computed without HREADY so the bus ready mux cannot close a loop.
  assign stall = !rst && dp_wr && buf_vld && HSEL && HTRANS[1] && !HWRITE && legal_now;

  assign load = !rst && dp_wr && HREADY;
  // Draining is held off during read waits so mem_q stays stable until captured.
  assign drain   = !rst && buf_vld && !rd_issue && (state != S_RD_WAIT);
  assign rd_now  = dp_rd && (state == S_IDLE) && (RD_WS == 0);
  assign rd_done = (state == S_RD_WAIT) && (cnt <= 2'd1);

  ahb_wbuf #(.AW(AW)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .drain    (drain),
    .ld_addr  (dp_addr),
    .ld_be    (dp_be),
    .ld_data  (HWDATA),
    .rd_word  (dp_addr[AW-1:2]),
    .rd_q     (mem_q),
    .merged   (merged),
    .buf_vld  (buf_vld),
    .buf_addr (buf_addr),
    .buf_be   (buf_be),
    .buf_data (buf_data)
  );

  assign mem_sel = rd_issue || drain;
  assign mem_wr  = drain;
  assign mem_a   = rd_issue ? HADDR[AW-1:0] : buf_addr;
  assign mem_be  = rd_issue ? be_now : buf_be;
  assign mem_d   = buf_data;

  assign HRDATA = rd_now ? merged : hrdata_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = AHB_OKAY;
    case (state)
      S_IDLE, S_ERR2: begin
        if (state == S_ERR2) HRESP = AHB_ERROR;
        if (stall) HREADYOUT = 1'b0;
        state_nxt = S_IDLE;
        if (ill_issue) begin
          state_nxt = S_ERR1;
        end else if (rd_issue && RD_WS > 0) begin
          state_nxt = S_RD_WAIT;
          cnt_nxt   = 2'(RD_WS);
        end
      end
      S_RD_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_nxt   = cnt - 2'd1;
        if (rd_done) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 2'd0;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = AHB_ERROR;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      dp_rd    <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      dp_be    <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (HREADY) begin
        dp_rd <= rd_issue;
        dp_wr <= wr_accept;
        if (accept) begin
          dp_addr <= HADDR[AW-1:0];
          dp_be   <= be_now;
        end
      end
      if (rd_now || rd_done) hrdata_q <= merged;
    end
  end

endmodule
